// File: rtl/mdu_pipelined_pkg.sv
// Shared definitions for the multiply/divide unit.
// MDU op codes (4-bit, carried on MDUCtrl), FSM state type and op
// classification helpers used by the top level and the calculator.
package mdu_pipelined_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MADD  = 4'd5;
    localparam logic [3:0] MDU_MADDU = 4'd6;
    localparam logic [3:0] MDU_MSUB  = 4'd7;
    localparam logic [3:0] MDU_MSUBU = 4'd8;
    localparam logic [3:0] MDU_MTHI  = 4'd9;
    localparam logic [3:0] MDU_MTLO  = 4'd10;
    localparam logic [3:0] MDU_MFHI  = 4'd11;
    localparam logic [3:0] MDU_MFLO  = 4'd12;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // Ops that occupy the unit for a latency period.
    function automatic logic is_arith(input logic [3:0] op);
        return (op >= MDU_MULT) && (op <= MDU_MSUBU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_pipelined_calc.sv
// Combinational result generator for the multiply/divide unit.
// Ports:
//   op          MDU op code
//   a, b        operands (rs, rt)
//   hi, lo      current HI/LO, used by accumulate ops and zero-divisor hold
//   p_hi, p_lo  pending result to be committed after the op latency
module mdu_pipelined_calc
    import mdu_pipelined_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] p_hi,
    output logic [WIDTH-1:0] p_lo
);

    logic [2*WIDTH-1:0] hilo;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic [2*WIDTH-1:0] res;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   q_m;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   q_s;
    logic [WIDTH-1:0]   r_s;
    logic [WIDTH-1:0]   q_u;
    logic [WIDTH-1:0]   r_u;

    always_comb begin
        hilo   = {hi, lo};
        // Sign-extended operands: the low 2W bits of the 2W x 2W product
        // are the exact signed product.
        prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
        prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

        // Signed divide via magnitudes. The most-negative / -1 case falls
        // out naturally: |a| = 2**(W-1), q = 2**(W-1), positive sign,
        // which wraps to the most-negative value with remainder 0.
        mag_a = a[WIDTH-1] ? -a : a;
        mag_b = b[WIDTH-1] ? -b : b;
        q_m   = '0;
        r_m   = '0;
        q_u   = '0;
        r_u   = '0;
        if (b != '0) begin
            q_m = mag_a / mag_b;
            r_m = mag_a % mag_b;
            q_u = a / b;
            r_u = a % b;
        end
        q_s = (a[WIDTH-1] ^ b[WIDTH-1]) ? -q_m : q_m;
        r_s = a[WIDTH-1] ? -r_m : r_m;

        res = hilo;
        case (op)
            MDU_MULT:  res = prod_s;
            MDU_MULTU: res = prod_u;
            MDU_MADD:  res = hilo + prod_s;
            MDU_MADDU: res = hilo + prod_u;
            MDU_MSUB:  res = hilo - prod_s;
            MDU_MSUBU: res = hilo - prod_u;
            MDU_DIV:   if (b != '0) res = {r_s, q_s};
            MDU_DIVU:  if (b != '0) res = {r_u, q_u};
            default:   res = hilo;
        endcase
        p_hi = res[2*WIDTH-1:WIDTH];
        p_lo = res[WIDTH-1:0];
    end

endmodule

// File: rtl/mdu_pipelined.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// The result is computed at accept time into pending registers and
// committed to HI/LO when the latency counter expires.
// Ports:
//   clk       clock, rising edge
//   reset     asynchronous active-low reset
//   start     E-stage instruction is an MDU op
//   MDUCtrl   op code
//   SrcA/SrcB rs/rt operands
//   cancel    issuing instruction is flushed; blocks acceptance
//   busy      an arithmetic op is in flight
//   stallReq  stall request to the hazard unit
//   HI/LO     architectural HI/LO
//
// state   | meaning
// IDLE    | ready; accepts arithmetic ops, performs MTHI/MTLO
// RUN     | op in flight; counter counts down to commit
module mdu_pipelined
    import mdu_pipelined_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CW      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       MDUCtrl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             cancel,
    output logic             busy,
    output logic             stallReq,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    mdu_state_e       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] p_hi;
    logic [WIDTH-1:0] p_lo;
    logic [WIDTH-1:0] calc_hi;
    logic [WIDTH-1:0] calc_lo;

    mdu_pipelined_calc #(.WIDTH(WIDTH)) u_calc (
        .op   (MDUCtrl),
        .a    (SrcA),
        .b    (SrcB),
        .hi   (HI),
        .lo   (LO),
        .p_hi (calc_hi),
        .p_lo (calc_lo)
    );

    assign stallReq = (busy | start) & (MDUCtrl != MDU_NONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            p_hi  <= '0;
            p_lo  <= '0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !cancel) begin
                        if (is_arith(MDUCtrl)) begin
                            p_hi  <= calc_hi;
                            p_lo  <= calc_lo;
                            cnt   <= is_div(MDUCtrl) ? CW'(DIV_LAT) : CW'(MUL_LAT);
                            state <= ST_RUN;
                            busy  <= 1'b1;
                        end else if (MDUCtrl == MDU_MTHI) begin
                            HI <= SrcA;
                        end else if (MDUCtrl == MDU_MTLO) begin
                            LO <= SrcA;
                        end
                    end
                end
                ST_RUN: begin
                    // cancel is deliberately ignored here: an accepted op commits.
                    if (cnt == CW'(1)) begin
                        HI    <= p_hi;
                        LO    <= p_lo;
                        cnt   <= '0;
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
